// File: rtl/rr_resource_scheduler_if.sv
// Bundle of requester-side and resource-side signals for the round-robin
// resource scheduler. The slave modport is the scheduler's view. The master
// modport is the view of the surrounding requesters and resource.
interface rr_resource_scheduler_if #(
    parameter int TOTAL  = 4,
    parameter int WIDTH  = 8,
    parameter int RWIDTH = 8
);
    localparam int SW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    // requester side
    logic [TOTAL-1:0]       req_stb;
    logic [TOTAL*WIDTH-1:0] req_data;
    logic [TOTAL-1:0]       req_busy;
    logic [TOTAL-1:0]       rsp_stb;
    logic [RWIDTH-1:0]      rsp_data;
    logic                   rsp_err;

    // resource side
    logic                   cmd_stb;
    logic [WIDTH-1:0]       cmd_data;
    logic [SW-1:0]          cmd_src;
    logic                   res_rdy;
    logic                   res_done;
    logic [RWIDTH-1:0]      res_data;

    modport slave (
        input  req_stb, req_data, res_rdy, res_done, res_data,
        output req_busy, rsp_stb, rsp_data, rsp_err, cmd_stb, cmd_data, cmd_src
    );

    modport master (
        output req_stb, req_data, res_rdy, res_done, res_data,
        input  req_busy, rsp_stb, rsp_data, rsp_err, cmd_stb, cmd_data, cmd_src
    );
endinterface

// File: rtl/rr_resource_scheduler.sv
// Round-robin scheduler sharing one single-transaction resource among TOTAL
// requesters. Each requester's command word is latched on its strobe. One
// command is issued at a time. The scheduler waits for completion or a
// timeout, then pulses the response back to the requester that issued it.
module rr_resource_scheduler #(
    parameter int TOTAL   = 4,
    parameter int WIDTH   = 8,
    parameter int RWIDTH  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    rr_resource_scheduler_if.slave bus
);
    localparam int SW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    // A counter of at least one bit keeps TIMEOUT=0 (timeout disabled) legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]    TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [TOTAL-1:0] ONE_HOT = TOTAL'(1);
    localparam logic [SW-1:0]    LAST_RST = SW'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [TOTAL-1:0]  pending_q;
    logic [TOTAL-1:0]  pending_d;
    logic [TOTAL-1:0]  cap_s;
    logic [WIDTH-1:0]  data_q [TOTAL];
    logic [SW-1:0]     last_q;
    logic [SW-1:0]     cmd_src_q;
    logic              cmd_stb_q;
    logic [WIDTH-1:0]  cmd_data_q;
    logic [TOTAL-1:0]  rsp_stb_q;
    logic [RWIDTH-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [CW-1:0]     tmo_cnt_q;
    logic              grant_vld_s;
    logic [SW-1:0]     grant_idx_s;

    // Requester index reached by stepping 'off' places past 'base', wrapping at TOTAL.
    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int off);
        int sum_v;
        sum_v = (int'(base) + off) % TOTAL;
        return sum_v[SW-1:0];
    endfunction

    // Per-requester capture and pending next-state. In RESP, a fresh strobe from the
    // requester being answered re-arms it instead of letting the clear win.
    always_comb begin
        pending_d = pending_q;
        cap_s     = '0;
        for (int i = 0; i < TOTAL; i++) begin
            if ((state_q == RESP) && (cmd_src_q == SW'(i))) begin
                cap_s[i]     = bus.req_stb[i];
                pending_d[i] = bus.req_stb[i];
            end else begin
                cap_s[i]     = bus.req_stb[i] & ~pending_q[i];
                pending_d[i] = pending_q[i] | bus.req_stb[i];
            end
        end
    end

    // Round-robin pick: the first pending requester after the last one served.
    // The search runs farthest-first so the nearest hit is the one that sticks.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        for (int k = TOTAL; k >= 1; k--) begin
            if (pending_q[wrap_idx(last_q, k)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = wrap_idx(last_q, k);
            end else begin
                grant_vld_s = grant_vld_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Scheduler FSM with request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            last_q     <= LAST_RST;
            cmd_src_q  <= '0;
            cmd_stb_q  <= 1'b0;
            cmd_data_q <= '0;
            rsp_stb_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            for (int i = 0; i < TOTAL; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < TOTAL; i++) begin
                if (cap_s[i]) begin
                    data_q[i] <= bus.req_data[WIDTH*i +: WIDTH];
                end
            end

            case (state_q)
                IDLE: begin
                    if (grant_vld_s && bus.res_rdy) begin
                        cmd_src_q  <= grant_idx_s;
                        cmd_data_q <= data_q[grant_idx_s];
                        cmd_stb_q  <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_stb_q <= 1'b0;
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (bus.res_done) begin
                        rsp_data_q <= bus.res_data;
                        rsp_err_q  <= 1'b0;
                        rsp_stb_q  <= ONE_HOT << cmd_src_q;
                        state_q    <= RESP;
                    end else if ((TIMEOUT != 0) && (tmo_cnt_q == TO_LAST)) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        rsp_stb_q  <= ONE_HOT << cmd_src_q;
                        state_q    <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rsp_stb_q <= '0;
                    last_q    <= cmd_src_q;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_busy = pending_q;
    assign bus.rsp_stb  = rsp_stb_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.cmd_stb  = cmd_stb_q;
    assign bus.cmd_data = cmd_data_q;
    assign bus.cmd_src  = cmd_src_q;
endmodule

// File: doc/rr_resource_scheduler.md
Name: rr_resource_scheduler

Overview:
Round-robin scheduler that shares one single-transaction resource between TOTAL requesters. It latches each requester's command word on a strobe and issues one command at a time to the resource. It waits for the resource's completion or a timeout, then routes the response back to the originating requester as a one-cycle pulse. It sits between requester blocks and a shared resource such as a bus master or sensor interface.

Parameters:
TOTAL, 4, number of requesters (>=2)
WIDTH, 8, command word width per requester
RWIDTH, 8, response word width
TIMEOUT, 255, cycles to wait in WAIT before aborting; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_stb  in  TOTAL  per-requester request strobe; latches its slice of req_data
req_data  in  TOTAL*WIDTH  command words; requester i uses bits [WIDTH*i +: WIDTH]
req_busy  out  TOTAL  requester i has a pending or in-flight command
rsp_stb  out  TOTAL  one-cycle completion pulse to originating requester
rsp_data  out  RWIDTH  response word, valid while any rsp_stb bit is high
rsp_err  out  1  timeout flag, valid with rsp_stb
cmd_stb  out  1  one-cycle command issue pulse to the resource
cmd_data  out  WIDTH  command word, valid with cmd_stb and held until RESP
cmd_src  out  $clog2(TOTAL)  index of the granted requester, held from ISSUE through RESP
res_rdy  in  1  resource idle and able to accept a command
res_done  in  1  resource completion pulse
res_data  in  RWIDTH  resource result, sampled with res_done

Behaviour:
- Reset values:
  - state=IDLE; pending=0.
  - req_busy=0, rsp_stb=0, rsp_err=0, cmd_stb=0, rsp_data=0, cmd_data=0, cmd_src=0.
  - Round-robin pointer last=TOTAL-1, so requester 0 has first priority.
- Request latch:
  - req_stb[i] with pending[i]=0 sets pending[i] and captures the data slice at the same edge.
  - req_stb[i] while pending[i]=1 is ignored, and the data is not recaptured.
  - Exception: in the RESP cycle for the selected requester, set wins over clear and the new data is captured.
- req_busy = pending (registered). It rises the cycle after req_stb and falls the cycle after rsp_stb.
- FSM:
  - IDLE: if any pending and res_rdy, grant the first pending index searching from last+1 with wrap-around, register it into cmd_src, go to ISSUE. Otherwise stay.
  - ISSUE: cmd_stb=1 for exactly one cycle; cmd_data = the latched word of cmd_src; clear the timeout counter; go to WAIT.
  - WAIT:
    - On res_done, capture res_data into rsp_data, set rsp_err=0, go to RESP.
    - Else if TIMEOUT!=0 and the counter equals TIMEOUT-1, set rsp_data=0, rsp_err=1, go to RESP.
    - Else increment the counter.
    - If res_done and timeout coincide, res_done wins.
  - RESP: rsp_stb[cmd_src]=1 for one cycle; clear pending[cmd_src] unless re-requested; last<=cmd_src; go to IDLE.
- Latency:
  - req_stb at cycle 0 gives cmd_stb at cycle 2 (resource idle, no contention).
  - res_done at cycle N gives rsp_stb at N+1.
  - The next cmd_stb occurs no earlier than N+3.
- res_done outside WAIT is ignored. res_rdy is only sampled in IDLE.
- Timeout counter width is $clog2(TIMEOUT+1).
- At most one rsp_stb bit is high in any cycle; cmd_stb is never high outside ISSUE.
- Reset mid-operation returns to IDLE, drops all pending requests, emits no rsp_stb, and leaves the resource un-notified.

Test Plan:
- Single request: TOTAL=4, req_stb=0010, data 0xA5, res_rdy=1.
  - cmd_stb at cycle 2 with cmd_data=0xA5, cmd_src=1.
  - res_done with res_data=0x3C at cycle 5 gives rsp_stb=0010, rsp_data=0x3C, rsp_err=0 at cycle 6.
  - req_busy[1] is high during cycles 1-6.
- Simultaneous requests: req_stb=1111 with distinct data and immediate res_done each time.
  - Grants in order 0,1,2,3, each rsp_stb routed to the matching bit.
- Fairness: requester 0 re-strobes during every RESP cycle while requester 2 is pending.
  - Grants alternate 0,2,0,2; requester 0 never starves requester 2.
  - Each re-strobe in RESP keeps req_busy[0] high and recaptures the data.
- Timeout: TIMEOUT=10, request from requester 3, res_done never asserted.
  - rsp_stb=1000, rsp_err=1, rsp_data=0 exactly 10 cycles after the cycle following cmd_stb.
  - A later res_done pulse is ignored.
- Stall: res_rdy=0 with requester 2 pending for 20 cycles gives no cmd_stb; raising res_rdy gives cmd_stb 1 cycle later.
- Reset mid-WAIT: assert rst for 1 cycle in WAIT.
  - All outputs return to reset values and no rsp_stb is emitted.
  - After reset, requester 0 wins over requester 3 when both request together.
